// File: rtl/boot_pkg.sv
// Shared types and constants for the UART program boot loader.
package boot_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        BODY,
        RUN,
        ERR
    } boot_state_t;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned WORD_WIDTH = 32;
    localparam int unsigned BYTE_WIDTH = 8;

endpackage

// File: rtl/byte_packer.sv
// Packs big-endian UART bytes into 32-bit words; flags the word on its 4th byte.
module byte_packer
    import boot_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  rx_valid,
    input  logic [BYTE_WIDTH-1:0] rx_data,
    output logic                  word_valid_c,
    output logic [WORD_WIDTH-1:0] word_c
);

    localparam int unsigned CNT_W   = $clog2(WORD_BYTES);
    localparam int unsigned SHIFT_W = WORD_WIDTH - BYTE_WIDTH;

    logic [CNT_W-1:0]   byte_cnt;
    logic [SHIFT_W-1:0] shift;

    // The completing byte is taken straight from the input so the word is usable in the same cycle.
    assign word_valid_c = rx_valid && !clear && (byte_cnt == CNT_W'(WORD_BYTES - 1));
    assign word_c       = {shift, rx_data};

    // Byte counter and shift register of the earlier bytes of the current word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt <= '0;
            shift    <= '0;
        end else if (clear) begin
            byte_cnt <= '0;
        end else if (rx_valid) begin
            byte_cnt <= byte_cnt + CNT_W'(1);
            shift    <= {shift[SHIFT_W-BYTE_WIDTH-1:0], rx_data};
        end
    end

endmodule

// File: rtl/boot_loader.sv
// Loads a length-prefixed program from the UART into instruction memory, then releases the CPU.
module boot_loader
    import boot_pkg::*;
#(
    parameter int unsigned INST_MEM_WIDTH = 5,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      load_req,
    input  logic                      rx_valid,
    input  logic [BYTE_WIDTH-1:0]     rx_data,
    output logic                      inst_we,
    output logic [INST_MEM_WIDTH-1:0] inst_addr,
    output logic [WORD_WIDTH-1:0]     inst_wdata,
    output logic                      cpu_rst,
    output logic                      cpu_run,
    output logic                      busy,
    output logic                      err,
    output logic [INST_MEM_WIDTH:0]   inst_count
);

    localparam int unsigned CNT_W = INST_MEM_WIDTH + 1;
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0]      TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WORD_WIDTH-1:0] MAX_WORDS = WORD_WIDTH'(1) << INST_MEM_WIDTH;

    boot_state_t           state;
    logic [CNT_W-1:0]      word_cnt;
    logic [TMO_W-1:0]      tmo_cnt;
    logic                  seen_byte;

    logic                  loading_c;
    logic                  pk_valid_c;
    logic                  pk_clear_c;
    logic                  timeout_c;
    logic                  word_valid_c;
    logic [WORD_WIDTH-1:0] word_c;

    // Bytes only count while loading; load_req beats a coincident byte, and a timeout drops the partial word.
    assign loading_c  = (state == HDR) || (state == BODY);
    assign pk_valid_c = rx_valid && loading_c && !load_req;
    assign timeout_c  = loading_c && seen_byte && !rx_valid && (tmo_cnt == TMO_LAST);
    assign pk_clear_c = load_req || !loading_c || timeout_c;

    byte_packer u_byte_packer (
        .clk          (CLK),
        .rst          (RST),
        .clear        (pk_clear_c),
        .rx_valid     (pk_valid_c),
        .rx_data      (rx_data),
        .word_valid_c (word_valid_c),
        .word_c       (word_c)
    );

    // Load sequencer: header length, body writes, inter-byte timeout and all registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            word_cnt   <= '0;
            tmo_cnt    <= '0;
            seen_byte  <= 1'b0;
            inst_we    <= 1'b0;
            inst_addr  <= '0;
            inst_wdata <= '0;
            cpu_rst    <= 1'b1;
            cpu_run    <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
            inst_count <= '0;
        end else begin
            inst_we <= 1'b0;
            if (load_req) begin
                state     <= HDR;
                word_cnt  <= '0;
                tmo_cnt   <= '0;
                seen_byte <= 1'b0;
                err       <= 1'b0;
                cpu_rst   <= 1'b1;
                cpu_run   <= 1'b0;
                busy      <= 1'b1;
            end else begin
                case (state)
                    HDR, BODY: begin
                        if (pk_valid_c) begin
                            seen_byte <= 1'b1;
                            tmo_cnt   <= '0;
                        end else if (timeout_c) begin
                            state <= ERR;
                            err   <= 1'b1;
                            busy  <= 1'b0;
                        end else if (seen_byte) begin
                            tmo_cnt <= tmo_cnt + TMO_W'(1);
                        end

                        if (word_valid_c) begin
                            if (state == HDR) begin
                                if (word_c == '0) begin
                                    state      <= RUN;
                                    inst_count <= '0;
                                    cpu_rst    <= 1'b0;
                                    cpu_run    <= 1'b1;
                                    busy       <= 1'b0;
                                end else if (word_c > MAX_WORDS) begin
                                    state <= ERR;
                                    err   <= 1'b1;
                                    busy  <= 1'b0;
                                end else begin
                                    state      <= BODY;
                                    inst_count <= word_c[INST_MEM_WIDTH:0];
                                end
                            end else begin
                                inst_we    <= 1'b1;
                                inst_addr  <= word_cnt[INST_MEM_WIDTH-1:0];
                                inst_wdata <= word_c;
                                word_cnt   <= word_cnt + CNT_W'(1);
                                if ((word_cnt + CNT_W'(1)) == inst_count) begin
                                    state   <= RUN;
                                    cpu_rst <= 1'b0;
                                    cpu_run <= 1'b1;
                                    busy    <= 1'b0;
                                end
                            end
                        end
                    end
                    default: begin
                        // IDLE, RUN and ERR hold until the next load_req.
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// Directed, table-driven bench for boot_loader (INST_MEM_WIDTH=5, TIMEOUT_CYCLES=100).
module tb_boot_loader;

    localparam int unsigned IMW = 5;
    localparam int unsigned TMO = 100;

    logic           clk = 1'b0;
    logic           rst;
    logic           load_req;
    logic           rx_valid;
    logic [7:0]     rx_data;
    logic           inst_we;
    logic [IMW-1:0] inst_addr;
    logic [31:0]    inst_wdata;
    logic           cpu_rst;
    logic           cpu_run;
    logic           busy;
    logic           err;
    logic [IMW:0]   inst_count;

    int checks = 0;
    int errors = 0;

    // Write log captured on the falling edge.
    int             wr_count = 0;
    logic [IMW-1:0] wr_addr_a [0:255];
    logic [31:0]    wr_data_a [0:255];

    typedef struct packed {
        logic        lr;
        logic        v;
        logic [7:0]  d;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        busy;
        logic        run;
    } vec_t;

    vec_t tbl [0:18];

    boot_loader #(
        .INST_MEM_WIDTH (IMW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .CLK        (clk),
        .RST        (rst),
        .load_req   (load_req),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .inst_we    (inst_we),
        .inst_addr  (inst_addr),
        .inst_wdata (inst_wdata),
        .cpu_rst    (cpu_rst),
        .cpu_run    (cpu_run),
        .busy       (busy),
        .err        (err),
        .inst_count (inst_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (inst_we) begin
            wr_addr_a[wr_count[7:0]] <= inst_addr;
            wr_data_a[wr_count[7:0]] <= inst_wdata;
            wr_count <= wr_count + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock with the given inputs; returns 1 time unit after the edge.
    task automatic cyc(input logic lr, input logic v, input logic [7:0] d);
        load_req = lr;
        rx_valid = v;
        rx_data  = d;
        @(posedge clk);
        #1;
        load_req = 1'b0;
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, w[31-8*i -: 8]);
    endtask

    function automatic vec_t mk(input logic lr, input logic v, input logic [7:0] d,
                                input logic we, input logic [4:0] a, input logic [31:0] dat,
                                input logic b, input logic r);
        vec_t t;
        t.lr = lr; t.v = v; t.d = d; t.we = we;
        t.addr = a; t.data = dat; t.busy = b; t.run = r;
        return t;
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, " cpu_rst"}, 32'(cpu_rst), 1);
        chk({tag, " cpu_run"}, 32'(cpu_run), 0);
        chk({tag, " inst_we"}, 32'(inst_we), 0);
        chk({tag, " inst_addr"}, 32'(inst_addr), 0);
        chk({tag, " inst_wdata"}, inst_wdata, 0);
        chk({tag, " busy"}, 32'(busy), 0);
        chk({tag, " err"}, 32'(err), 0);
        chk({tag, " inst_count"}, 32'(inst_count), 0);
    endtask

    initial begin
        int base;
        int bad;

        // Main-load table: inputs for one cycle, outputs expected right after that edge.
        tbl[0]  = mk(1'b1, 1'b0, 8'h00, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        tbl[1]  = mk(1'b0, 1'b1, 8'h00, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        tbl[2]  = mk(1'b0, 1'b1, 8'h00, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        tbl[3]  = mk(1'b0, 1'b1, 8'h00, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        tbl[4]  = mk(1'b0, 1'b1, 8'h03, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        tbl[5]  = mk(1'b0, 1'b1, 8'h20, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        tbl[6]  = mk(1'b0, 1'b1, 8'h01, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        tbl[7]  = mk(1'b0, 1'b1, 8'h00, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        tbl[8]  = mk(1'b0, 1'b1, 8'h05, 1'b1, 5'd0, 32'h20010005, 1'b1, 1'b0);
        tbl[9]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        tbl[10] = mk(1'b0, 1'b1, 8'h20, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        tbl[11] = mk(1'b0, 1'b1, 8'h02, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        tbl[12] = mk(1'b0, 1'b1, 8'h00, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        tbl[13] = mk(1'b0, 1'b1, 8'h07, 1'b1, 5'd1, 32'h20020007, 1'b1, 1'b0);
        tbl[14] = mk(1'b0, 1'b1, 8'h00, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        tbl[15] = mk(1'b0, 1'b1, 8'h22, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        tbl[16] = mk(1'b0, 1'b1, 8'h18, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        tbl[17] = mk(1'b0, 1'b1, 8'h20, 1'b1, 5'd2, 32'h00221820, 1'b0, 1'b1);
        tbl[18] = mk(1'b0, 1'b1, 8'hff, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);

        rst      = 1'b1;
        load_req = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rst = 1'b0;
        cyc(1'b0, 1'b0, 8'h00);

        // Bytes without load_req are ignored.
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b1, 8'($urandom_range(0, 255)));
            chk("idle we", 32'(inst_we), 0);
        end
        chk("idle cpu_rst", 32'(cpu_rst), 1);
        chk("idle cpu_run", 32'(cpu_run), 0);
        chk("idle busy", 32'(busy), 0);

        // Three-word program from the table.
        for (int i = 0; i < 19; i++) begin
            cyc(tbl[i].lr, tbl[i].v, tbl[i].d);
            chk($sformatf("tbl%0d we", i), 32'(inst_we), 32'(tbl[i].we));
            chk($sformatf("tbl%0d busy", i), 32'(busy), 32'(tbl[i].busy));
            chk($sformatf("tbl%0d run", i), 32'(cpu_run), 32'(tbl[i].run));
            if (tbl[i].we) begin
                chk($sformatf("tbl%0d addr", i), 32'(inst_addr), 32'(tbl[i].addr));
                chk($sformatf("tbl%0d data", i), inst_wdata, tbl[i].data);
            end
        end
        chk("tbl inst_count", 32'(inst_count), 3);
        chk("tbl cpu_rst", 32'(cpu_rst), 0);
        chk("tbl err", 32'(err), 0);

        // Full memory: N=32 sent back to back.
        cyc(1'b1, 1'b0, 8'h00);
        chk("full cpu_run cleared", 32'(cpu_run), 0);
        chk("full cpu_rst set", 32'(cpu_rst), 1);
        base = wr_count;
        send_word(32'h0000_0020);
        for (int k = 0; k < 32; k++) send_word(32'hA500_0000 | 32'(k));
        chk("full run", 32'(cpu_run), 1);
        cyc(1'b0, 1'b0, 8'h00);
        chk("full writes", wr_count - base, 32);
        bad = 0;
        for (int k = 0; k < 32; k++) begin
            if (wr_addr_a[8'(base + k)] !== IMW'(k)) bad++;
            if (wr_data_a[8'(base + k)] !== (32'hA500_0000 | 32'(k))) bad++;
        end
        chk("full addr/data errors", bad, 0);
        chk("full last addr", 32'(wr_addr_a[8'(base + 31)]), 31);
        chk("full inst_count", 32'(inst_count), 32);
        chk("full busy", 32'(busy), 0);

        // N=33 exceeds memory depth.
        cyc(1'b1, 1'b0, 8'h00);
        base = wr_count;
        send_word(32'h0000_0021);
        cyc(1'b0, 1'b0, 8'h00);
        chk("over err", 32'(err), 1);
        chk("over writes", wr_count - base, 0);
        chk("over busy", 32'(busy), 0);
        chk("over cpu_run", 32'(cpu_run), 0);
        chk("over cpu_rst", 32'(cpu_rst), 1);

        // Timeout after a partial second word.
        cyc(1'b1, 1'b0, 8'h00);
        chk("tmo err cleared", 32'(err), 0);
        base = wr_count;
        send_word(32'h0000_0002);
        send_word(32'h1122_3344);
        cyc(1'b0, 1'b1, 8'h55);
        cyc(1'b0, 1'b1, 8'h66);
        repeat (TMO - 1) cyc(1'b0, 1'b0, 8'h00);
        chk("tmo early err", 32'(err), 0);
        chk("tmo early busy", 32'(busy), 1);
        cyc(1'b0, 1'b0, 8'h00);
        chk("tmo err", 32'(err), 1);
        chk("tmo busy", 32'(busy), 0);
        chk("tmo cpu_rst", 32'(cpu_rst), 1);
        chk("tmo writes", wr_count - base, 1);
        chk("tmo addr", 32'(wr_addr_a[8'(base)]), 0);
        chk("tmo data", wr_data_a[8'(base)], 32'h1122_3344);

        // load_req with a coincident byte mid-body restarts cleanly.
        cyc(1'b1, 1'b0, 8'h00);
        send_word(32'h0000_0002);
        send_word(32'hCAFE_F00D);
        cyc(1'b0, 1'b1, 8'h01);
        cyc(1'b0, 1'b1, 8'h02);
        cyc(1'b1, 1'b1, 8'h00);
        chk("restart busy", 32'(busy), 1);
        base = wr_count;
        send_word(32'h0000_0001);
        send_word(32'hDEAD_BEEF);
        chk("restart we", 32'(inst_we), 1);
        chk("restart addr", 32'(inst_addr), 0);
        chk("restart data", inst_wdata, 32'hDEAD_BEEF);
        chk("restart run", 32'(cpu_run), 1);
        cyc(1'b0, 1'b0, 8'h00);
        chk("restart writes", wr_count - base, 1);
        chk("restart inst_count", 32'(inst_count), 1);

        // Asynchronous reset mid-body, then an empty program.
        cyc(1'b1, 1'b0, 8'h00);
        send_word(32'h0000_0003);
        send_word(32'h0102_0304);
        cyc(1'b0, 1'b1, 8'hAA);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_vals("async rst");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        cyc(1'b1, 1'b0, 8'h00);
        base = wr_count;
        send_word(32'h0000_0000);
        chk("empty run", 32'(cpu_run), 1);
        chk("empty cpu_rst", 32'(cpu_rst), 0);
        chk("empty busy", 32'(busy), 0);
        chk("empty inst_count", 32'(inst_count), 0);
        cyc(1'b0, 1'b0, 8'h00);
        chk("empty writes", wr_count - base, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
